dcct_adc_rdr: RTL



---
 rtl/psc_adc_pkg.sv | 22 ++
 rtl/dcct_adc_rdr_if.sv | 25 ++
 rtl/dcct_adc_rdr_shift_ch.sv | 24 ++
 rtl/dcct_adc_rdr.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/psc_adc_pkg.sv
// Shared types and constants for the DCCT ADC reader.
// Reader FSM states, channel count and default word width.
package psc_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNV,
    WAIT_BUSY,
    SHIFT,
    DONE
  } rdr_state_t;

  localparam int DCCT_NUM_CH = 4;
  localparam int DCCT_DATA_W = 20;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcct_adc_rdr_if.sv
// Pin bundle between the reader and the four DCCT SAR ADCs.
// Master is the reader; slave is the ADC side.
interface dcct_adc_rdr_if;
  import psc_adc_pkg::*;

  logic                   cnv;
  logic                   sck;
  logic [DCCT_NUM_CH-1:0] busy;
  logic [DCCT_NUM_CH-1:0] sdo;

  modport master (
    output cnv,
    output sck,
    input  busy,
    input  sdo
  );

  modport slave (
    input  cnv,
    input  sck,
    output busy,
    output sdo
  );

endinterface

// File: rtl/dcct_adc_rdr_shift_ch.sv
// One ADC channel's MSB-first receive shift register.
// Cleared at the start of each sample, shifts on enable.
module adc_shift_ch #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              sdo,
  output logic [DATA_W-1:0] word
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (shift_en) begin
      word <= {word[DATA_W-2:0], sdo};
    end
  end

endmodule

// File: rtl/dcct_adc_rdr.sv
// Parallel reader for the four DCCT SAR ADCs: cnv pulse,
// busy wait with blanking and timeout, shared-sck shift-in.
module dcct_adc_rdr
  import psc_adc_pkg::*;
#(
  parameter int DATA_W       = DCCT_DATA_W,
  parameter int CLK_DIV      = 2,
  parameter int CNV_CYCLES   = 4,
  parameter int BUSY_BLANK   = 8,
  parameter int BUSY_TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   err_clr,
  dcct_adc_rdr_if.master         dcct_adc,
  output logic [DCCT_NUM_CH-1:0]
               [DATA_W-1:0]      data,
  output logic                   data_valid,
  output logic                   rdr_busy,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int CW =
    $clog2(max3(CNV_CYCLES, BUSY_BLANK, BUSY_TIMEOUT) + 1);
  localparam int VW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W);

  localparam logic [CW-1:0] CNV_LAST  = CW'(CNV_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BUSY_BLANK);
  localparam logic [CW-1:0] TMO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [VW-1:0] DIV_LAST  = VW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  rdr_state_t             state;
  logic [CW-1:0]          cnt;
  logic [VW-1:0]          dcnt;
  logic [BW-1:0]          bcnt;
  logic                   cnv;
  logic                   sck;
  logic [DCCT_NUM_CH-1:0] busy_m;
  logic [DCCT_NUM_CH-1:0] busy_s;
  logic                   sck_edge;
  logic                   shift_en;
  logic                   clr;

  logic [DCCT_NUM_CH-1:0][DATA_W-1:0] word;

  assign dcct_adc.cnv = cnv;
  assign dcct_adc.sck = sck;
  assign rdr_busy     = (state != IDLE);
  assign sck_edge     = (state == SHIFT) && (dcnt == DIV_LAST);
  // sdo is launched on sck fall, so capture on the rising toggle
  assign shift_en     = sck_edge && !sck;
  assign clr          = (state == IDLE) && start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_m <= '0;
      busy_s <= '0;
    end else begin
      busy_m <= dcct_adc.busy;
      busy_s <= busy_m;
    end
  end

  for (genvar i = 0; i < DCCT_NUM_CH; i++) begin : g_ch
    adc_shift_ch #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (clr),
      .shift_en(shift_en),
      .sdo     (dcct_adc.sdo[i]),
      .word    (word[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dcnt        <= '0;
      bcnt        <= '0;
      cnv         <= 1'b0;
      sck         <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start && state != IDLE) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (err_clr) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= CNV;
            cnv   <= 1'b1;
            cnt   <= '0;
          end
        end
        CNV: begin
          if (cnt == CNV_LAST) begin
            state <= WAIT_BUSY;
            cnv   <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (cnt >= BLANK_END && busy_s == '0) begin
            state <= SHIFT;
            dcnt  <= '0;
            bcnt  <= '0;
          end else if (cnt == TMO_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (sck_edge) begin
            dcnt <= '0;
            sck  <= !sck;
            if (sck) begin
              if (bcnt == BIT_LAST) begin
                state <= DONE;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          data       <= word;
          data_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
